fir: RTL and testbench

FIR -- requirements
Module: fir

---
 rtl/fir.sv | 123 ++++++++++++
 tb/tb_fir.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fir.sv
// fir: 15-tap symmetric low-pass FIR filter with AXI-Stream style handshakes.
//
// One input sample is accepted per clock while the output register is empty
// or being drained. The output register is loaded on the same edge as the
// accept, so there is one clock of latency from input to output.
//
// Ports
//   clk                 system clock, rising-edge active
//   reset               asynchronous reset, active low
//   s_axis_fir_tdata    signed 16-bit input sample
//   s_axis_fir_tvalid   input sample valid
//   s_axis_fir_tlast    input end-of-packet marker
//   s_axis_fir_tready   block can accept a sample (combinational)
//   m_axis_fir_tdata    signed 32-bit filter output
//   m_axis_fir_tvalid   output sample valid
//   m_axis_fir_tlast    end-of-packet marker for the output sample
//   m_axis_fir_tkeep    byte enables, all bytes always valid
//   m_axis_fir_tready   downstream accepts the output sample
module fir #(
    parameter int NTAPS  = 15,
    parameter int COEF_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] s_axis_fir_tdata,
    input  logic        s_axis_fir_tvalid,
    input  logic        s_axis_fir_tlast,
    output logic        s_axis_fir_tready,
    output logic [31:0] m_axis_fir_tdata,
    output logic        m_axis_fir_tvalid,
    output logic        m_axis_fir_tlast,
    output logic [3:0]  m_axis_fir_tkeep,
    input  logic        m_axis_fir_tready
);

    // Coefficient set is defined for 15 taps; any extra taps read as zero.
    localparam int NCOEF = 15;
    localparam int COEF_TBL [NCOEF] = '{
        -82, -134, 0, 650, 1900, 3551, 5023, 5600,
        5023, 3551, 1900, 650, 0, -134, -82
    };

    function automatic logic signed [COEF_W-1:0] coef(input int k);
        logic signed [COEF_W-1:0] c;
        c = '0;
        if (k < NCOEF) begin
            c = COEF_W'(COEF_TBL[k]);
        end
        return c;
    endfunction

    logic signed [15:0] x_q [NTAPS];
    logic signed [15:0] x_d [NTAPS];
    logic [31:0]        tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic               accept;
    logic signed [31:0] acc;
    logic signed [COEF_W+15:0] prod;

    assign s_axis_fir_tready = ~tvalid_q | m_axis_fir_tready;
    assign accept            = s_axis_fir_tvalid & s_axis_fir_tready;

    // Post-shift delay line: the newest sample contributes to this output.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            x_d[k] = x_q[k];
        end
        if (accept) begin
            for (int k = NTAPS - 1; k > 0; k--) begin
                x_d[k] = x_q[k-1];
            end
            x_d[0] = s_axis_fir_tdata;
        end
    end

    // Exact sum; the coefficient magnitudes keep |y| below 2^30.
    always_comb begin
        acc  = '0;
        prod = '0;
        for (int k = 0; k < NTAPS; k++) begin
            prod = coef(k) * x_d[k];
            acc  = acc + 32'(prod);
        end
    end

    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        if (accept) begin
            tdata_d  = acc;
            tvalid_d = 1'b1;
            tlast_d  = s_axis_fir_tlast;
        end else if (m_axis_fir_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= '0;
            end
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= x_d[k];
            end
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign m_axis_fir_tdata  = tdata_q;
    assign m_axis_fir_tvalid = tvalid_q;
    assign m_axis_fir_tlast  = tlast_q;
    assign m_axis_fir_tkeep  = 4'hF;

endmodule

// File: tb/tb_fir.sv
module tb_fir;

    logic        clk;
    logic        reset;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [3:0]  m_tkeep;
    logic        m_tready;

    int errors = 0;
    int checks = 0;

    fir dut (
        .clk               (clk),
        .reset             (reset),
        .s_axis_fir_tdata  (s_tdata),
        .s_axis_fir_tvalid (s_tvalid),
        .s_axis_fir_tlast  (s_tlast),
        .s_axis_fir_tready (s_tready),
        .m_axis_fir_tdata  (m_tdata),
        .m_axis_fir_tvalid (m_tvalid),
        .m_axis_fir_tlast  (m_tlast),
        .m_axis_fir_tkeep  (m_tkeep),
        .m_axis_fir_tready (m_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: history of accepted samples (newest first) and the
    // register a downstream consumer would see.
    int H [15] = '{-82, -134, 0, 650, 1900, 3551, 5023, 5600,
                   5023, 3551, 1900, 650, 0, -134, -82};
    int IMP [15] = '{-82, -134, 0, 650, 1900, 3551, 5023, 5600,
                     5023, 3551, 1900, 650, 0, -134, -82};
    int hist[$];
    int exp_data;
    bit exp_valid;
    bit exp_last;

    function automatic int dot();
        int s = 0;
        for (int k = 0; k < 15; k++) s += H[k] * hist[k];
        return s;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 15; k++) hist.push_back(0);
        exp_data  = 0;
        exp_valid = 0;
        exp_last  = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".tvalid"}, 32'(m_tvalid), 32'(exp_valid));
        chk({tag, ".tdata"}, m_tdata, exp_data);
        chk({tag, ".tlast"}, 32'(m_tlast), 32'(exp_last));
        chk({tag, ".tkeep"}, 32'(m_tkeep), 32'hF);
    endtask

    // One clock: drive inputs just after an edge, check ready, clock, check outputs.
    task automatic step(input logic v, input logic [15:0] d, input logic l,
                        input logic mr, input string tag);
        bit rdy;
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = mr;
        #1;
        rdy = !exp_valid || mr;
        chk({tag, ".s_tready"}, 32'(s_tready), 32'(rdy));
        @(posedge clk);
        if (v && rdy) begin
            hist.push_front(int'($signed(d)));
            void'(hist.pop_back());
            exp_data  = dot();
            exp_valid = 1;
            exp_last  = l;
        end else if (mr) begin
            exp_valid = 0;
        end
        #1;
        chk_outputs(tag);
    endtask

    // Asynchronous reset asserted away from the clock edge; input activity
    // during reset must be ignored.
    task automatic do_reset(input string tag);
        #2;
        reset    = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 16'h1234;
        s_tlast  = 1'b1;
        m_tready = 1'b1;
        model_reset();
        #1;
        chk_outputs({tag, ".async"});
        chk({tag, ".s_tready"}, 32'(s_tready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk_outputs({tag, ".held"});
        reset    = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    logic [15:0] sine [8] = '{16'h0000, 16'h5A7E, 16'h7FFF, 16'h5A7E,
                              16'h0000, 16'hA582, 16'h8000, 16'hA582};

    initial begin
        reset    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        model_reset();
        #3;
        chk_outputs("por");
        chk("por.s_tready", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Impulse, tlast marked on sample 7 only.
        for (int i = 0; i < 15; i++) begin
            step(1'b1, (i == 0) ? 16'd1 : 16'd0, i == 7, 1'b1, "impulse");
            chk("impulse.table", m_tdata, IMP[i]);
            chk("impulse.tlast", 32'(m_tlast), 32'(i == 7));
        end
        step(1'b0, 16'd0, 1'b0, 1'b1, "impulse.drain");

        // Impulse with a 5-cycle input gap in the middle.
        do_reset("rst_gap");
        for (int i = 0; i < 15; i++) begin
            if (i == 6) begin
                for (int g = 0; g < 5; g++) begin
                    step(1'b0, 16'hDEAD, 1'b0, 1'b1, "gap.idle");
                    chk("gap.tvalid_low", 32'(m_tvalid), 32'd0);
                end
            end
            step(1'b1, (i == 0) ? 16'd1 : 16'd0, 1'b0, 1'b1, "gap");
            chk("gap.table", m_tdata, IMP[i]);
        end

        // Positive and negative full-scale steps.
        do_reset("rst_step");
        for (int i = 0; i < 20; i++) step(1'b1, 16'h7FFF, 1'b0, 1'b1, "step_pos");
        chk("step_pos.settle", m_tdata, 32'd898340072);
        do_reset("rst_stepn");
        for (int i = 0; i < 20; i++) step(1'b1, 16'h8000, 1'b0, 1'b1, "step_neg");
        chk("step_neg.settle", m_tdata, -32'sd898367488);

        // Backpressure for 10 clocks while the source keeps offering data.
        do_reset("rst_bp");
        for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b1, "bp.pre");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'($urandom), 1'b0, 1'b0, "bp.hold");
            chk("bp.s_tready_low", 32'(s_tready), 32'd0);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 1'b0, 1'b1, "bp.post");

        // Sine stream, reset mid-stream, then the same stream from scratch.
        for (int i = 0; i < 12; i++) step(1'b1, sine[i % 8], 1'b0, 1'b1, "sine.a");
        do_reset("rst_sine");
        for (int i = 0; i < 16; i++) begin
            step(1'b1, sine[i % 8], i == 15, 1'b1, "sine.b");
            if (i == 1) chk("sine.b.second", m_tdata, -32'sd1899612);
        end

        // Randomized traffic: valid, ready, last and data all random.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 3) != 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
